// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: 2-flop synchronizer, counter debouncer,
// registered press/release pulses and a long-press "held" indication.
module button_conditioner #(
    parameter int unsigned N               = 5,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned HOLD_CYCLES     = 100000000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] btn_raw,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    // `release` is a reserved word, hence the suffix.
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] held
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } state_e;

    state_e        state_q    [N];
    state_e        state_d    [N];
    logic [DW-1:0] db_cnt_q   [N];
    logic [DW-1:0] db_cnt_d   [N];
    logic [HW-1:0] hold_cnt_q [N];
    logic [HW-1:0] hold_cnt_d [N];

    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;
    logic [N-1:0] press_q, press_d;
    logic [N-1:0] release_q, release_d;
    logic [N-1:0] rise, fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i]    <= ST_IDLE;
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int unsigned i = 0; i < N; i++) begin
                state_q[i]    <= state_d[i];
                db_cnt_q[i]   <= db_cnt_d[i];
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    // Debounce: a toggle is requested once sync has disagreed with level
    // for DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        rise    = '0;
        fall    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    rise[i] = sync2_q[i];
                    fall[i] = ~sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d   = rise;
        release_d = fall;
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            state_d[i]    = state_q[i];
            hold_cnt_d[i] = '0;
            case (state_q[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        state_d[i] = ST_PRESSED;
                    end
                end
                ST_PRESSED: begin
                    hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                    if (fall[i]) begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
                    end else if (hold_cnt_d[i] == HOLD_MAX) begin
                        state_d[i] = ST_HELD;
                    end
                end
                ST_HELD: begin
                    hold_cnt_d[i] = hold_cnt_q[i];
                    if (fall[i]) begin
                        state_d[i]    = ST_IDLE;
                        hold_cnt_d[i] = '0;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        level         = '0;
        held          = '0;
        press         = press_q;
        release_pulse = release_q;
        for (int unsigned i = 0; i < N; i++) begin
            level[i] = (state_q[i] != ST_IDLE);
            held[i]  = (state_q[i] == ST_HELD);
        end
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
- REQ-001 Parameter N, default 5: number of independent button channels.
- REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz); legal range 2 and above.
- REQ-003 Parameter HOLD_CYCLES, default 100000000: cycles a debounced press must persist before held asserts (1 s at 100 MHz); SHALL exceed DEBOUNCE_CYCLES.
- REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
- REQ-005 reset_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion takes effect on the next clk edge.
- REQ-006 btn_raw  input  N  asynchronous, bouncing, active-high button levels.
- REQ-007 level  output  N  debounced button level, one bit per channel.
- REQ-008 press  output  N  one-cycle pulse on each debounced 0->1 transition.
- REQ-009 release  output  N  one-cycle pulse on each debounced 1->0 transition.
- REQ-010 held  output  N  high while a channel has been debounced-high for at least HOLD_CYCLES cycles.

Function
- REQ-011 Each channel SHALL be processed independently by identical logic; no cross-channel interaction.
- REQ-012 Each btn_raw bit SHALL pass through a 2-flop synchronizer; only the second flop output (sync) feeds the debouncer.
- REQ-013 Per channel, a debounce counter, sized ceil(log2(DEBOUNCE_CYCLES+1)) bits, SHALL count cycles where sync != level and clear to 0 in any cycle where sync == level.
- REQ-014 When the counter would reach DEBOUNCE_CYCLES, level SHALL toggle on that edge and the counter SHALL clear to 0; the counter never exceeds DEBOUNCE_CYCLES-1 otherwise.
- REQ-015 Latency: a raw change held clean SHALL appear on level exactly 2 + DEBOUNCE_CYCLES clk cycles after the first edge at which btn_raw is sampled changed.
- REQ-016 A glitch shorter than DEBOUNCE_CYCLES cycles at sync SHALL NOT change level and SHALL restart the count from 0.
- REQ-017 press SHALL be high for exactly the first cycle in which level is 1 after being 0; release likewise for the first cycle level is 0 after being 1; both registered, never simultaneous on one channel.
- REQ-018 A hold counter per channel SHALL clear while level is 0, increment each cycle level is 1, and saturate at HOLD_CYCLES (no wrap).
- REQ-019 held SHALL assert in the cycle the hold counter reaches HOLD_CYCLES (HOLD_CYCLES cycles after press) and remain high until level falls; held SHALL deassert in the same cycle release pulses.
- REQ-020 Simultaneous changes on several channels SHALL be handled in parallel with identical per-channel timing.
- REQ-021 Channel state machine: IDLE (level 0) -> PRESSED (level 1, hold counting) -> HELD (held 1); PRESSED or HELD -> IDLE on debounced fall; no other transitions.

Reset
- REQ-022 While reset_n is 0: synchronizers, debounce and hold counters, level, press, release and held SHALL all be 0.
- REQ-023 Reset asserted mid-count or mid-hold SHALL discard partial counts; after release a button already held high SHALL need the full 2 + DEBOUNCE_CYCLES cycles and SHALL produce one press pulse.
- REQ-024 No press, release or held pulse SHALL be generated by reset assertion or deassertion itself.

Verification (bench with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, N=5)
- REQ-025 Clean press: btn_raw[0] 0->1 held -> level[0]=1 exactly 6 cycles later, press[0]=1 for that one cycle only, other channels unchanged.
- REQ-026 Bounce: btn_raw[1] toggles 1,0,1,0 with 2-cycle widths then stays 1 -> level[1] rises 6 cycles after final edge; exactly one press[1] pulse.
- REQ-027 Glitch: btn_raw[2] high for 3 cycles then low -> level[2], press[2], release[2] stay 0 throughout.
- REQ-028 Hold: btn_raw[3] held 1 for 30 cycles then 0 -> held[3] rises 10 cycles after press[3]; on debounced fall held[3]=0 and release[3]=1 in the same cycle.
- REQ-029 Reset mid-operation: btn_raw[4]=1, reset_n pulsed low 2 cycles after level[4] rises -> all outputs 0 immediately; after reset_n=1, level[4] returns 6 cycles later with one press[4] pulse.
- REQ-030 Parallel: all five btn_raw bits rise on the same edge -> all level bits and press pulses assert in the same cycle.
